// File: rtl/enc_pipe.sv
// Two-stage extended-Hamming (SECDED) encoder for (8,4), (16,11) and (32,26) codewords.
// Optional fault injection on the stage-2 codeword is enabled by defining ENC_FAULT_INJ_EN.
module enc_pipe #(
    parameter int MAX_CODEWORD_WIDTH = 32,
    parameter int MAX_INFO_WIDTH     = 26
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [MAX_INFO_WIDTH-1:0]     data_in,
    input  logic [1:0]                    work_mod,
`ifdef ENC_FAULT_INJ_EN
    input  logic                          inj_en,
    input  logic [MAX_CODEWORD_WIDTH-1:0] inj_vec,
`endif
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [MAX_CODEWORD_WIDTH-1:0] data_out,
    output logic                          mode_err
);

    localparam int MAX_PARITY_WIDTH = MAX_CODEWORD_WIDTH - MAX_INFO_WIDTH;
    localparam int IW = MAX_INFO_WIDTH;
    localparam int PW = MAX_PARITY_WIDTH - 1;

    // Clear info bits above K; the illegal mode passes the full word through.
    function automatic logic [IW-1:0] mask_info(input logic [IW-1:0] d, input logic [1:0] m);
        case (m)
            2'b00:   return d & IW'(26'h000000F);
            2'b01:   return d & IW'(26'h00007FF);
            2'b10:   return d & IW'(26'h3FFFFFF);
            default: return d;
        endcase
    endfunction

    function automatic logic [PW-1:0] parity_low(input logic [IW-1:0] i, input logic [1:0] m);
        logic [PW-1:0] p;
        p = '0;
        case (m)
            2'b00: begin
                p[0] = ^(i & IW'(26'h000000B));
                p[1] = ^(i & IW'(26'h000000D));
                p[2] = ^(i & IW'(26'h000000E));
            end
            2'b01: begin
                p[0] = ^(i & IW'(26'h000055B));
                p[1] = ^(i & IW'(26'h000066D));
                p[2] = ^(i & IW'(26'h000078E));
                p[3] = ^(i & IW'(26'h00007F0));
            end
            2'b10: begin
                p[0] = ^(i & IW'(26'h2AAAD5B));
                p[1] = ^(i & IW'(26'h333366D));
                p[2] = ^(i & IW'(26'h3C3C78E));
                p[3] = ^(i & IW'(26'h3FC07F0));
                p[4] = ^(i & IW'(26'h3FFF800));
            end
            default: p = '0;
        endcase
        return p;
    endfunction

    // Overall parity bit makes the whole codeword even weight; info is already masked.
    function automatic logic [MAX_CODEWORD_WIDTH-1:0] build_codeword(
        input logic [IW-1:0] i, input logic [PW-1:0] pl, input logic [1:0] m);
        logic top;
        top = (^i) ^ (^pl);
        case (m)
            2'b00:   return {24'h000000, i[3:0], top, pl[2:0]};
            2'b01:   return {16'h0000, i[10:0], top, pl[3:0]};
            2'b10:   return {i[25:0], top, pl[4:0]};
            default: return {6'h00, i};
        endcase
    endfunction

    function automatic logic [MAX_CODEWORD_WIDTH-1:0] cw_mask(input logic [1:0] m);
        case (m)
            2'b00:   return 32'h000000FF;
            2'b01:   return 32'h0000FFFF;
            2'b10:   return 32'hFFFFFFFF;
            default: return 32'h00000000;
        endcase
    endfunction

    logic                          s1_valid_r;
    logic [IW-1:0]                 s1_info_r;
    logic [1:0]                    s1_mode_r;
    logic [PW-1:0]                 s1_par_r;
    logic                          out_valid_r;
    logic [MAX_CODEWORD_WIDTH-1:0] data_out_r;
    logic                          mode_err_r;
    logic                          advance_s;
    logic                          in_ready_s;
    logic                          accept_s;
    logic [IW-1:0]                 info_masked_s;
    logic [MAX_CODEWORD_WIDTH-1:0] cw_s;
`ifdef ENC_FAULT_INJ_EN
    logic                          s1_inj_en_r;
    logic [MAX_CODEWORD_WIDTH-1:0] s1_inj_vec_r;
`endif

    assign advance_s     = !out_valid_r || out_ready;
    assign in_ready_s    = !s1_valid_r || advance_s;
    assign accept_s      = in_valid && in_ready_s;
    assign info_masked_s = mask_info(data_in, work_mod);

    // Stage-2 codeword assembly, with optional error injection after parity.
    always_comb begin
        cw_s = build_codeword(s1_info_r, s1_par_r, s1_mode_r);
`ifdef ENC_FAULT_INJ_EN
        if (s1_inj_en_r) begin
            cw_s = cw_s ^ (s1_inj_vec_r & cw_mask(s1_mode_r));
        end else begin
            cw_s = cw_s;
        end
`endif
    end

    // Stage 1: capture masked info, mode and low parity bits on handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_r   <= 1'b0;
            s1_info_r    <= '0;
            s1_mode_r    <= 2'b00;
            s1_par_r     <= '0;
`ifdef ENC_FAULT_INJ_EN
            s1_inj_en_r  <= 1'b0;
            s1_inj_vec_r <= '0;
`endif
        end else if (accept_s) begin
            s1_valid_r   <= 1'b1;
            s1_info_r    <= info_masked_s;
            s1_mode_r    <= work_mod;
            s1_par_r     <= parity_low(info_masked_s, work_mod);
`ifdef ENC_FAULT_INJ_EN
            s1_inj_en_r  <= inj_en;
            s1_inj_vec_r <= inj_vec;
`endif
        end else if (advance_s) begin
            s1_valid_r   <= 1'b0;
        end
    end

    // Stage 2: registered output codeword, held while downstream stalls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_r <= 1'b0;
            data_out_r  <= '0;
            mode_err_r  <= 1'b0;
        end else if (advance_s) begin
            out_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                data_out_r <= cw_s;
                mode_err_r <= (s1_mode_r == 2'b11);
            end
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign data_out  = data_out_r;
    assign mode_err  = mode_err_r;

endmodule

// File: tb/tb_enc_pipe.sv
// Directed bench for enc_pipe: hand-computed codewords, streaming, stall and reset flush.
module tb_enc_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [25:0] data_in = 26'h0;
    logic [1:0]  work_mod = 2'b00;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] data_out;
    logic        mode_err;
`ifdef ENC_FAULT_INJ_EN
    logic        inj_en = 1'b0;
    logic [31:0] inj_vec = 32'h0;
`endif

    int total = 0;
    int bad   = 0;

    logic [1:0]  v_mode [8];
    logic [25:0] v_data [8];
    logic [31:0] v_cw   [8];
    logic        v_err  [8];

    enc_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .work_mod  (work_mod),
`ifdef ENC_FAULT_INJ_EN
        .inj_en    (inj_en),
        .inj_vec   (inj_vec),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .mode_err  (mode_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // One isolated word with out_ready held high; checks latency and result.
    task automatic send_one(input string tag, input logic [1:0] m, input logic [25:0] d,
                            input logic [31:0] cw, input logic err);
        work_mod = m;
        data_in  = d;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({tag, "_lat_early"}, {31'h0, out_valid}, 32'h0);
        @(posedge clk); #1;
        check({tag, "_valid"}, {31'h0, out_valid}, 32'h1);
        check({tag, "_data"}, data_out, cw);
        check({tag, "_err"}, {31'h0, mode_err}, {31'h0, err});
    endtask

    initial begin
        int idx_in;
        int idx_out;
        logic [31:0] held;
        logic hold_valid;
        logic saw_low;

        v_mode[0] = 2'b00; v_data[0] = 26'h0000001; v_cw[0] = 32'h0000001B; v_err[0] = 1'b0;
        v_mode[1] = 2'b01; v_data[1] = 26'h3FFF801; v_cw[1] = 32'h00000033; v_err[1] = 1'b0;
        v_mode[2] = 2'b10; v_data[2] = 26'h0000001; v_cw[2] = 32'h00000063; v_err[2] = 1'b0;
        v_mode[3] = 2'b00; v_data[3] = 26'h0000008; v_cw[3] = 32'h00000087; v_err[3] = 1'b0;
        v_mode[4] = 2'b11; v_data[4] = 26'h3FFFFFF; v_cw[4] = 32'h03FFFFFF; v_err[4] = 1'b1;
        v_mode[5] = 2'b00; v_data[5] = 26'h3FFFFF2; v_cw[5] = 32'h0000002D; v_err[5] = 1'b0;
        v_mode[6] = 2'b01; v_data[6] = 26'h0000400; v_cw[6] = 32'h0000801F; v_err[6] = 1'b0;
        v_mode[7] = 2'b10; v_data[7] = 26'h2000000; v_cw[7] = 32'h8000001F; v_err[7] = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {31'h0, out_valid}, 32'h0);
        check("rst_data_out", data_out, 32'h0);
        check("rst_mode_err", {31'h0, mode_err}, 32'h0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", {31'h0, in_ready}, 32'h1);

        // Isolated words
        send_one("m00_1", 2'b00, 26'h0000001, 32'h0000001B, 1'b0);
        send_one("m00_f", 2'b00, 26'h000000F, 32'h000000FF, 1'b0);
        send_one("m01_1", 2'b01, 26'h0000001, 32'h00000033, 1'b0);
        send_one("m10_1", 2'b10, 26'h0000001, 32'h00000063, 1'b0);
        send_one("m11",   2'b11, 26'h3FFFFFF, 32'h03FFFFFF, 1'b1);
        send_one("m00_after_err", 2'b00, 26'h0000008, 32'h00000087, 1'b0);
        @(posedge clk); #1;
        check("drain_valid_low", {31'h0, out_valid}, 32'h0);

        // Back-to-back stream: one codeword per cycle, in order
        for (int c = 0; c < 9; c++) begin
            in_valid = (c < 8);
            if (c < 8) begin
                work_mod = v_mode[c];
                data_in  = v_data[c];
            end
            #1;
            if (c < 8) check("stream_in_ready", {31'h0, in_ready}, 32'h1);
            @(posedge clk); #1;
            if (c >= 1) begin
                check("stream_valid", {31'h0, out_valid}, 32'h1);
                check("stream_data", data_out, v_cw[c-1]);
                check("stream_err", {31'h0, mode_err}, {31'h0, v_err[c-1]});
                if (!v_err[c-1]) check("stream_even", {31'h0, ^data_out}, 32'h0);
            end
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("stream_drained", {31'h0, out_valid}, 32'h0);

        // Stall: out_ready low for 5 cycles while streaming
        idx_in = 0;
        idx_out = 0;
        held = 32'h0;
        hold_valid = 1'b0;
        saw_low = 1'b0;
        for (int c = 0; c < 60 && idx_out < 8; c++) begin
            out_ready = !(c >= 3 && c < 8);
            in_valid  = (idx_in < 8);
            if (idx_in < 8) begin
                work_mod = v_mode[idx_in];
                data_in  = v_data[idx_in];
            end
            #1;
            if (hold_valid) begin
                check("stall_valid_hold", {31'h0, out_valid}, 32'h1);
                check("stall_data_hold", data_out, held);
            end
            if (!in_ready) saw_low = 1'b1;
            hold_valid = out_valid && !out_ready;
            held = data_out;
            if (out_valid && out_ready) begin
                check("stall_word", data_out, v_cw[idx_out]);
                check("stall_err", {31'h0, mode_err}, {31'h0, v_err[idx_out]});
                idx_out++;
            end
            if (in_valid && in_ready) idx_in++;
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("stall_all_out", idx_out, 32'd8);
        check("stall_in_ready_fell", {31'h0, saw_low}, 32'h1);
        check("stall_drained", {31'h0, out_valid}, 32'h0);

        // Reset with both stages full
        out_ready = 1'b0;
        in_valid  = 1'b1;
        work_mod  = 2'b11;
        data_in   = 26'h3FFFFFF;
        @(posedge clk); #1;
        work_mod  = 2'b00;
        data_in   = 26'h000000F;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        check("full_valid", {31'h0, out_valid}, 32'h1);
        check("full_err", {31'h0, mode_err}, 32'h1);
        check("full_in_ready", {31'h0, in_ready}, 32'h0);
        #1;
        rst = 1'b0;
        #1;
        check("async_rst_valid", {31'h0, out_valid}, 32'h0);
        check("async_rst_data", data_out, 32'h0);
        check("async_rst_err", {31'h0, mode_err}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("post_rst_idle", {31'h0, out_valid}, 32'h0);
        send_one("post_rst", 2'b00, 26'h0000001, 32'h0000001B, 1'b0);

`ifdef ENC_FAULT_INJ_EN
        inj_en  = 1'b1;
        inj_vec = 32'h00000100;
        send_one("inj_masked", 2'b00, 26'h0000001, 32'h0000001B, 1'b0);
        inj_vec = 32'h00000004;
        send_one("inj_bit2", 2'b00, 26'h0000001, 32'h0000001F, 1'b0);
        inj_en  = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
